// File: rtl/star_scan_sequencer.sv
// rtl/star_scan_sequencer.sv - raster scan of the image ROM, launching the measurement engine on uncovered lit pixels
`timescale 1ns/1ps
module star_scan_sequencer #(
  parameter int XSZ       = 6,
  parameter int YSZ       = 6,
  parameter int ADDR_SZ   = 12,
  parameter int COL_SZ    = 3,
  parameter int X_RES     = 60,
  parameter int Y_RES     = 60,
  parameter int THRESHOLD = 0,
  parameter int MAX_STARS = 4,
  localparam int IDX_SZ   = $clog2(MAX_STARS),
  localparam int CNT_SZ   = $clog2(MAX_STARS + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  output logic [ADDR_SZ-1:0] pixAddr,
  input  logic [COL_SZ-1:0]  pixVal,
  output logic               starFound,
  output logic [XSZ-1:0]     xOut,
  output logic [YSZ-1:0]     yOut,
  input  logic               measDone,
  input  logic [XSZ-1:0]     measRight,
  input  logic [YSZ-1:0]     measTop,
  input  logic [YSZ-1:0]     measBottom,
  input  logic [IDX_SZ-1:0]  rdIdx,
  output logic [XSZ-1:0]     rdLeft,
  output logic [XSZ-1:0]     rdRight,
  output logic [YSZ-1:0]     rdTop,
  output logic [YSZ-1:0]     rdBottom,
  output logic [CNT_SZ-1:0]  starCount,
  output logic               busy,
  output logic               frameDone,
  output logic               overflow
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CHECK, S_LAUNCH, S_WAIT_CLR,
    S_WAIT_DONE, S_STORE, S_ADVANCE, S_DONE
  } state_t;

  state_t              r_state;
  state_t              r_next;
  logic [XSZ-1:0]      r_x;
  logic [YSZ-1:0]      r_y;
  logic [XSZ-1:0]      r_xout;
  logic [YSZ-1:0]      r_yout;
  logic [CNT_SZ-1:0]   r_count;
  logic                r_overflow;
  logic [XSZ-1:0]      r_left   [MAX_STARS];
  logic [XSZ-1:0]      r_right  [MAX_STARS];
  logic [YSZ-1:0]      r_top    [MAX_STARS];
  logic [YSZ-1:0]      r_bottom [MAX_STARS];

  logic                w_lit;
  logic                w_covered;
  logic                w_new_star;
  logic                w_full;
  logic                w_last;
  logic                w_x_wrap;
  logic                w_start;
  logic [IDX_SZ-1:0]   w_wr_idx;

  assign w_lit      = (pixVal != COL_SZ'(THRESHOLD));
  assign w_full     = (r_count == CNT_SZ'(MAX_STARS));
  assign w_x_wrap   = (r_x == XSZ'(X_RES - 1));
  assign w_last     = w_x_wrap && (r_y == YSZ'(Y_RES - 1));
  assign w_new_star = (r_state == S_CHECK) && w_lit && !w_covered;
  assign w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && go;
  assign w_wr_idx   = r_count[IDX_SZ-1:0];

  // Only entries below starCount count; stale entries from an earlier frame are ignored.
  always_comb begin
    w_covered = 1'b0;
    for (int i = 0; i < MAX_STARS; i++) begin
      if ((CNT_SZ'(i) < r_count) &&
          (r_left[i] <= r_x) && (r_x <= r_right[i]) &&
          (r_top[i] <= r_y) && (r_y <= r_bottom[i])) begin
        w_covered = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (go) r_next = S_FETCH;
      S_FETCH:        r_next = S_CHECK;
      S_CHECK: begin
        if (w_lit && !w_covered) begin
          r_next = w_full ? S_DONE : S_LAUNCH;
        end else begin
          r_next = S_ADVANCE;
        end
      end
      S_LAUNCH:       r_next = S_WAIT_CLR;
      S_WAIT_CLR:     r_next = S_WAIT_DONE;
      S_WAIT_DONE:    if (measDone) r_next = S_STORE;
      S_STORE:        r_next = S_ADVANCE;
      S_ADVANCE:      r_next = w_last ? S_DONE : S_FETCH;
      default:        r_next = S_IDLE;
    endcase
  end

  always_comb begin
    starFound = (r_state == S_LAUNCH);
    frameDone = (r_state == S_DONE);
    busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x        <= '0;
      r_y        <= '0;
      r_xout     <= '0;
      r_yout     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < MAX_STARS; i++) begin
        r_left[i]   <= '0;
        r_right[i]  <= '0;
        r_top[i]    <= '0;
        r_bottom[i] <= '0;
      end
    end else begin
      if (w_start) begin
        r_x        <= '0;
        r_y        <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      // Launch coordinate is latched on the CHECK->LAUNCH edge so it is valid with starFound.
      if (w_new_star) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_xout <= r_x;
          r_yout <= r_y;
        end
      end
      if (r_state == S_STORE) begin
        r_left[w_wr_idx]   <= r_xout;
        r_right[w_wr_idx]  <= measRight;
        r_top[w_wr_idx]    <= measTop;
        r_bottom[w_wr_idx] <= measBottom;
        r_count            <= r_count + CNT_SZ'(1);
      end
      if ((r_state == S_ADVANCE) && !w_last) begin
        if (w_x_wrap) begin
          r_x <= '0;
          r_y <= r_y + YSZ'(1);
        end else begin
          r_x <= r_x + XSZ'(1);
        end
      end
    end
  end

  assign pixAddr   = ADDR_SZ'(r_y) * ADDR_SZ'(X_RES) + ADDR_SZ'(r_x);
  assign xOut      = r_xout;
  assign yOut      = r_yout;
  assign starCount = r_count;
  assign overflow  = r_overflow;
  assign rdLeft    = r_left[rdIdx];
  assign rdRight   = r_right[rdIdx];
  assign rdTop     = r_top[rdIdx];
  assign rdBottom  = r_bottom[rdIdx];

endmodule

// File: tb/tb_star_scan_sequencer.sv
// tb/tb_star_scan_sequencer.sv - scoreboard bench for star_scan_sequencer with ROM and engine models
`timescale 1ns/1ps
module tb_star_scan_sequencer;

  typedef struct {int x; int y;} launch_t;
  typedef struct {int cnt; int ovf;} frame_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic [11:0] pixAddr;
  logic [2:0]  pixVal;
  logic        starFound;
  logic [5:0]  xOut;
  logic [5:0]  yOut;
  logic        measDone;
  logic [5:0]  measRight;
  logic [5:0]  measTop;
  logic [5:0]  measBottom;
  logic [1:0]  rdIdx;
  logic [5:0]  rdLeft;
  logic [5:0]  rdRight;
  logic [5:0]  rdTop;
  logic [5:0]  rdBottom;
  logic [2:0]  starCount;
  logic        busy;
  logic        frameDone;
  logic        overflow;

  logic [2:0]  rom [3600];
  launch_t     exp_launch[$];
  frame_t      exp_frame[$];
  int          checks = 0;
  int          errors = 0;
  int          eng_delay;
  int          eng_w;
  int          eng_h;
  bit          stale_mode;
  int          edges;
  int          busy_low;

  star_scan_sequencer dut (
    .clk(clk), .resetn(resetn), .go(go), .pixAddr(pixAddr), .pixVal(pixVal),
    .starFound(starFound), .xOut(xOut), .yOut(yOut), .measDone(measDone),
    .measRight(measRight), .measTop(measTop), .measBottom(measBottom),
    .rdIdx(rdIdx), .rdLeft(rdLeft), .rdRight(rdRight), .rdTop(rdTop),
    .rdBottom(rdBottom), .starCount(starCount), .busy(busy),
    .frameDone(frameDone), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pixVal <= rom[pixAddr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 3600; i++) rom[i] = 3'd0;
  endtask

  task automatic set_pix(input int x, input int y);
    rom[y * 60 + x] = 3'd5;
  endtask

  task automatic push_launch(input int x, input int y);
    launch_t l;
    l.x = x;
    l.y = y;
    exp_launch.push_back(l);
  endtask

  task automatic push_frame(input int cnt, input int ovf);
    frame_t f;
    f.cnt = cnt;
    f.ovf = ovf;
    exp_frame.push_back(f);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  // Counts edges after the go edge until frameDone; optionally pulses go once while busy.
  task automatic wait_done(input int go_at, output int n, output int low);
    n = 0;
    low = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (frameDone) break;
      if (!busy) low++;
      if (n >= 30000) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no frameDone after %0d edges", n);
        break;
      end
      go = (n == go_at);
    end
    go = 1'b0;
  endtask

  task automatic check_entry(input int idx, input int l, input int r, input int t, input int b);
    rdIdx = 2'(idx);
    #1;
    check("entry_left", int'(rdLeft), l);
    check("entry_right", int'(rdRight), r);
    check("entry_top", int'(rdTop), t);
    check("entry_bottom", int'(rdBottom), b);
    rdIdx = 2'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixAddr"}, int'(pixAddr), 0);
    check({tag, "_starFound"}, int'(starFound), 0);
    check({tag, "_xOut"}, int'(xOut), 0);
    check({tag, "_yOut"}, int'(yOut), 0);
    check({tag, "_starCount"}, int'(starCount), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frameDone"}, int'(frameDone), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check_entry(0, 0, 0, 0, 0);
  endtask

  initial begin
    resetn = 1'b0;
    go = 1'b0;
    measDone = 1'b0;
    measRight = '0;
    measTop = '0;
    measBottom = '0;
    rdIdx = '0;
    eng_delay = 5;
    eng_w = 1;
    eng_h = 1;
    stale_mode = 1'b0;
    clear_rom();

    fork
      begin : monitor
        launch_t lv;
        frame_t  fv;
        bit      prev_fd;
        prev_fd = 1'b0;
        forever begin
          @(negedge clk);
          if (resetn) begin
            if (starFound) begin
              if (exp_launch.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL launch_unexpected: got launch at x=%0d y=%0d, expected none", xOut, yOut);
              end else begin
                lv = exp_launch.pop_front();
                check("launch_x", int'(xOut), lv.x);
                check("launch_y", int'(yOut), lv.y);
              end
            end
            if (frameDone && !prev_fd) begin
              if (exp_frame.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got frameDone, expected none");
              end else begin
                fv = exp_frame.pop_front();
                check("frame_starCount", int'(starCount), fv.cnt);
                check("frame_overflow", int'(overflow), fv.ovf);
              end
            end
          end
          prev_fd = frameDone;
        end
      end
      begin : engine
        int lx;
        int ly;
        forever begin
          @(negedge clk);
          if (starFound) begin
            lx = int'(xOut);
            ly = int'(yOut);
            if (stale_mode) begin
              @(posedge clk);
              @(posedge clk);
              #1 measDone = 1'b0;
              repeat (3) @(posedge clk);
              #1;
              measRight = 6'd7;
              measTop = 6'd2;
              measBottom = 6'd4;
              measDone = 1'b1;
              stale_mode = 1'b0;
            end else begin
              measDone = 1'b0;
              repeat (eng_delay) @(posedge clk);
              #1;
              measRight = 6'(lx + eng_w - 1);
              measTop = 6'(ly);
              measBottom = 6'(ly + eng_h - 1);
              measDone = 1'b1;
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Blank frame
    push_frame(0, 0);
    pulse_go();
    wait_done(-1, edges, busy_low);
    check("blank_edges", edges, 10800);
    check("blank_busy_low", busy_low, 0);
    repeat (2) @(negedge clk);

    // 3x3 block
    for (int y = 20; y <= 22; y++)
      for (int x = 10; x <= 12; x++) set_pix(x, y);
    eng_w = 3;
    eng_h = 3;
    push_launch(10, 20);
    push_frame(1, 0);
    pulse_go();
    wait_done(-1, edges, busy_low);
    check_entry(0, 10, 12, 20, 22);
    repeat (2) @(negedge clk);

    // Five isolated pixels, table overflows at the fifth
    clear_rom();
    set_pix(5, 0);
    set_pix(20, 0);
    set_pix(40, 0);
    set_pix(5, 10);
    set_pix(5, 30);
    eng_w = 1;
    eng_h = 1;
    push_launch(5, 0);
    push_launch(20, 0);
    push_launch(40, 0);
    push_launch(5, 10);
    push_frame(4, 1);
    pulse_go();
    wait_done(-1, edges, busy_low);
    check("ovf_stop_x_addr", int'(pixAddr), 30 * 60 + 5);
    check_entry(3, 5, 5, 10, 10);
    repeat (2) @(negedge clk);

    // Stale measDone must not be captured
    clear_rom();
    set_pix(3, 2);
    measRight = 6'd50;
    measTop = 6'd50;
    measBottom = 6'd50;
    measDone = 1'b1;
    stale_mode = 1'b1;
    push_launch(3, 2);
    push_frame(1, 0);
    pulse_go();
    wait_done(-1, edges, busy_low);
    check_entry(0, 3, 7, 2, 4);
    repeat (2) @(negedge clk);

    // Reset during WAIT_DONE
    clear_rom();
    set_pix(2, 0);
    eng_delay = 50;
    push_launch(2, 0);
    pulse_go();
    begin
      int n;
      n = 0;
      while (!starFound && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rst_launch_seen", int'(starFound), 1);
    end
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (60) @(negedge clk);
    resetn = 1'b1;
    eng_delay = 5;
    push_launch(2, 0);
    push_frame(1, 0);
    pulse_go();
    check("restart_pixAddr", int'(pixAddr), 0);
    check("restart_busy", int'(busy), 1);
    wait_done(-1, edges, busy_low);
    check_entry(0, 2, 2, 0, 0);
    repeat (2) @(negedge clk);

    // Corner pixel, go while busy ignored, go in DONE restarts
    clear_rom();
    set_pix(59, 59);
    push_launch(59, 59);
    push_frame(1, 0);
    pulse_go();
    wait_done(200, edges, busy_low);
    check("corner_edges", edges, 10807);
    check_entry(0, 59, 59, 59, 59);
    push_launch(59, 59);
    push_frame(1, 0);
    pulse_go();
    check("redo_starCount", int'(starCount), 0);
    check("redo_frameDone", int'(frameDone), 0);
    check("redo_busy", int'(busy), 1);
    wait_done(-1, edges, busy_low);
    check("redo_edges", edges, 10807);

    repeat (3) @(negedge clk);
    check("launch_queue_left", exp_launch.size(), 0);
    check("frame_queue_left", exp_frame.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
